keys_switches: RTL and testbench
================================

KEYS_SWITCHES -- requirements
Module: keys_switches

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning CLK_50 cycles per debounce tick (1 kHz at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter DB_TICKS, default 10, meaning consecutive ticks an input must differ from its stable value before the stable value updates; legal range is 1 or more.
REQ-003 The block SHALL have port CLK_50, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port KEY, input, 4 bits: raw push-buttons, active-low (0 = pressed), asynchronous to CLK_50.
REQ-006 The block SHALL have port SW, input, 18 bits: raw slide switches, active-high, asynchronous to CLK_50.
REQ-007 The block SHALL have port KEY_DOWN, output, 4 bits: debounced key level, 1 = pressed.
REQ-008 The block SHALL have port KEY_PRESS, output, 4 bits: one-cycle pulse per bit on each debounced press.
REQ-009 The block SHALL have port KEY_RELEASE, output, 4 bits: one-cycle pulse per bit on each debounced release.
REQ-010 The block SHALL have port SW_STATE, output, 18 bits: debounced switch levels.
REQ-011 The block SHALL have port SW_CHANGE, output, 1 bit: one-cycle pulse when any SW_STATE bit changes.

Function
REQ-012 Each of the 22 inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A shared prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick for exactly one cycle when the count equals TICK_DIV-1.
REQ-014 Per bit, while the synchronized value equals the stable value, the debounce counter SHALL be held at 0.
REQ-015 Per bit, while the synchronized value differs from the stable value, the counter SHALL increment on each tick; a single return to equality SHALL clear it to 0.
REQ-016 Per bit, on a tick with the counter equal to DB_TICKS-1 and the input still differing, the stable value SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-017 Latency from a raw input change to the visible output SHALL lie between 2+(DB_TICKS-1)*TICK_DIV+1 and 2+DB_TICKS*TICK_DIV cycles.
REQ-018 KEY_DOWN SHALL equal the inverted stable key value; SW_STATE SHALL equal the stable switch value.
REQ-019 KEY_PRESS[i] SHALL be high exactly in the first cycle in which KEY_DOWN[i] reads 1 after reading 0.
REQ-020 KEY_RELEASE[i] SHALL be high exactly in the first cycle in which KEY_DOWN[i] reads 0 after reading 1.
REQ-021 SW_CHANGE SHALL be high exactly in the first cycle in which SW_STATE differs from its previous value; multiple bits changing in the same cycle SHALL produce one pulse.
REQ-022 Independent keys pressed in the same cycle SHALL each produce their own KEY_PRESS bit in that same cycle.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 RESET low SHALL immediately set KEY synchronizers and stable key values to 1 (released), SW synchronizers and stable switch values to 0, and all counters to 0.
REQ-025 RESET low SHALL immediately drive KEY_DOWN, KEY_PRESS, KEY_RELEASE, SW_STATE and SW_CHANGE to 0.
REQ-026 No press, release or change pulse SHALL be generated by reset assertion or deassertion itself.
REQ-027 An input held non-idle through reset SHALL be reported after the normal debounce latency following deassertion, with its pulse.

Structure
REQ-028 Shared package keys_switches_pkg SHALL hold NUM_KEYS=4, NUM_SW=18, the default TICK_DIV/DB_TICKS, and the counter-width function (ceil log2).
REQ-029 Per-bit synchronizer and debouncer SHALL be sub-module debounce_bit (parameters DB_TICKS, RESET_VAL), instantiated 22 times, with the prescaler shared at top level.

Verification (TICK_DIV=4, DB_TICKS=3)
REQ-030 KEY[0] driven low and held -> KEY_DOWN[0]=1 within 11-14 cycles, one KEY_PRESS[0] pulse; KEY[0] driven high -> KEY_RELEASE[0] pulse, KEY_DOWN[0]=0.
REQ-031 KEY[1] toggled every 3 cycles for 60 cycles, then held high -> KEY_DOWN[1] stays 0 and no pulses occur.
REQ-032 SW[0] and SW[17] set to 1 in the same cycle -> SW_STATE=18'h20001, exactly one SW_CHANGE pulse.
REQ-033 RESET asserted while KEY_DOWN=4'hF with KEY held at 0 -> outputs 0 at once; after deassertion, KEY_DOWN=4'hF and KEY_PRESS=4'hF pulse within 11-14 cycles.
REQ-034 All 4 KEY bits and 18 SW bits held for 1000 cycles -> prescaler wraps with a tick every 4 cycles, and no spurious pulses occur after the first transition.

Source files
------------

// File: rtl/keys_switches_pkg.sv
// ---------------------------------------------------------------------------
// keys_switches_pkg
// Shared constants for the key/switch debouncer:
//   NUM_KEYS, NUM_SW         - number of push-buttons and slide switches
//   TICK_DIV_DEFAULT         - clock cycles per debounce tick (1 kHz at 50 MHz)
//   DB_TICKS_DEFAULT         - ticks an input must stay changed to be accepted
//   cnt_width()              - ceil(log2(n)) with a floor of 1, used to size
//                              the prescaler and the per-bit debounce counters
// ---------------------------------------------------------------------------
package keys_switches_pkg;

  localparam int NUM_KEYS         = 4;
  localparam int NUM_SW           = 18;
  localparam int TICK_DIV_DEFAULT = 50000;
  localparam int DB_TICKS_DEFAULT = 10;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/keys_switches_if.sv
// ---------------------------------------------------------------------------
// keys_switches_if
// Bundles the raw board inputs and the debounced outputs of keys_switches.
//   KEY[3:0]         raw push-buttons, active-low
//   SW[17:0]         raw slide switches, active-high
//   KEY_DOWN[3:0]    debounced key level, 1 = pressed
//   KEY_PRESS[3:0]   one-cycle press pulse per key
//   KEY_RELEASE[3:0] one-cycle release pulse per key
//   SW_STATE[17:0]   debounced switch levels
//   SW_CHANGE        one-cycle pulse when any debounced switch changes
// master: drives the raw inputs (board / bench); slave: the debouncer.
// ---------------------------------------------------------------------------
interface keys_switches_if;
  import keys_switches_pkg::*;

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_SW-1:0]   SW;
  logic [NUM_KEYS-1:0] KEY_DOWN;
  logic [NUM_KEYS-1:0] KEY_PRESS;
  logic [NUM_KEYS-1:0] KEY_RELEASE;
  logic [NUM_SW-1:0]   SW_STATE;
  logic                SW_CHANGE;

  modport master (
    output KEY, SW,
    input  KEY_DOWN, KEY_PRESS, KEY_RELEASE, SW_STATE, SW_CHANGE
  );

  modport slave (
    input  KEY, SW,
    output KEY_DOWN, KEY_PRESS, KEY_RELEASE, SW_STATE, SW_CHANGE
  );

endinterface

// File: rtl/keys_switches_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Two-flop synchronizer followed by a tick-counting debouncer for one input.
//   clk       clock
//   rst_n     asynchronous active-low reset
//   tick_i    shared debounce tick (one cycle wide)
//   raw_i     raw asynchronous input
//   stable_o  debounced value (registered)
//   upd_o     high in the cycle before stable_o flips; lets the parent
//             register edge pulses that line up with the new stable value
// Parameters: DB_TICKS  consecutive ticks of disagreement needed to accept
//             RESET_VAL idle level loaded into synchronizer and stable value
// ---------------------------------------------------------------------------
module debounce_bit
  import keys_switches_pkg::*;
#(
  parameter int   DB_TICKS  = DB_TICKS_DEFAULT,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic upd_o
);

  localparam int CNT_W = cnt_width(DB_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    upd      = 1'b0;
    if (sync2_q == stable_q) begin
      // Any agreement, even for a single cycle, restarts the count.
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        upd      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = upd;

endmodule

// File: rtl/keys_switches.sv
// ---------------------------------------------------------------------------
// keys_switches
// Debounces the 4 board push-buttons and 18 slide switches and produces
// level outputs plus one-cycle press/release/change pulses.
//   CLK_50   single clock, rising edge
//   RESET    asynchronous active-low reset
//   bus      keys_switches_if.slave: KEY/SW in, KEY_DOWN/KEY_PRESS/
//            KEY_RELEASE/SW_STATE/SW_CHANGE out (all registered)
// Parameters: TICK_DIV clock cycles per debounce tick (>= 2)
//             DB_TICKS ticks of disagreement before a new level is accepted
// ---------------------------------------------------------------------------
module keys_switches
  import keys_switches_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
  input logic           CLK_50,
  input logic           RESET,
  keys_switches_if.slave bus
);

  localparam int PRE_W = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                tick;

  logic [NUM_KEYS-1:0] key_stable, key_upd;
  logic [NUM_SW-1:0]   sw_stable, sw_upd;

  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  logic                sw_change_q, sw_change_d;

  // Shared prescaler: one tick per TICK_DIV cycles for all 22 debouncers.
  assign tick = (presc_q == PRE_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) presc_d = '0;
  end

  genvar gi;
  generate
    // Keys idle high (released), so they reset to 1.
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      debounce_bit #(
        .DB_TICKS  (DB_TICKS),
        .RESET_VAL (1'b1)
      ) u_db (
        .clk      (CLK_50),
        .rst_n    (RESET),
        .tick_i   (tick),
        .raw_i    (bus.KEY[gi]),
        .stable_o (key_stable[gi]),
        .upd_o    (key_upd[gi])
      );
    end

    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_bit #(
        .DB_TICKS  (DB_TICKS),
        .RESET_VAL (1'b0)
      ) u_db (
        .clk      (CLK_50),
        .rst_n    (RESET),
        .tick_i   (tick),
        .raw_i    (bus.SW[gi]),
        .stable_o (sw_stable[gi]),
        .upd_o    (sw_upd[gi])
      );
    end
  endgenerate

  // An update always flips the stable value, so the current stable level
  // tells the direction: stable key 1 -> 0 is a press, 0 -> 1 a release.
  // Pulses are registered on the same edge as the stable value, so each
  // pulse coincides with the first cycle of the new level.
  always_comb begin
    key_press_d   = key_upd & key_stable;
    key_release_d = key_upd & ~key_stable;
    sw_change_d   = |sw_upd;
  end

  always_ff @(posedge CLK_50 or negedge RESET) begin
    if (!RESET) begin
      presc_q       <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      sw_change_q   <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      sw_change_q   <= sw_change_d;
    end
  end

  assign bus.KEY_DOWN    = ~key_stable;
  assign bus.SW_STATE    = sw_stable;
  assign bus.KEY_PRESS   = key_press_q;
  assign bus.KEY_RELEASE = key_release_q;
  assign bus.SW_CHANGE   = sw_change_q;

endmodule

// File: tb/tb_keys_switches.sv
// ---------------------------------------------------------------------------
// tb_keys_switches
// Self-checking bench for keys_switches with TICK_DIV=4, DB_TICKS=3.
// ---------------------------------------------------------------------------
module tb_keys_switches;
  import keys_switches_pkg::*;

  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  keys_switches_if ks_if ();

  keys_switches #(
    .TICK_DIV (TD),
    .DB_TICKS (DB)
  ) dut (
    .CLK_50 (clk),
    .RESET  (rst_n),
    .bus    (ks_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int press_cnt [NUM_KEYS];
  int rel_cnt   [NUM_KEYS];
  int chg_cnt;

  typedef struct {
    logic [3:0]  key;
    logic [17:0] sw;
    logic [3:0]  exp_down;
    logic [17:0] exp_sw;
    logic [3:0]  exp_press;
    logic [3:0]  exp_rel;
    int          exp_chg;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    chg_cnt = 0;
  endtask

  // One clock; sample 1 time unit after the rising edge and tally pulses.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_cnt[i] += int'(ks_if.KEY_PRESS[i]);
      rel_cnt[i]   += int'(ks_if.KEY_RELEASE[i]);
    end
    chg_cnt += int'(ks_if.SW_CHANGE);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_pulses(input string tag, input logic [3:0] pm, input logic [3:0] rm,
                              input int chg);
    for (int i = 0; i < NUM_KEYS; i++) begin
      check($sformatf("%s_press%0d", tag, i), press_cnt[i], {31'd0, pm[i]});
      check($sformatf("%s_release%0d", tag, i), rel_cnt[i], {31'd0, rm[i]});
    end
    check($sformatf("%s_swchange", tag), chg_cnt, chg);
  endtask

  // Counts cycles until KEY_DOWN equals exp (bounded); -1 if never seen.
  task automatic wait_down(input logic [3:0] exp, output int lat, output logic [3:0] press_seen);
    lat = -1;
    press_seen = '0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (ks_if.KEY_DOWN == exp) begin
        lat = n;
        press_seen = ks_if.KEY_PRESS;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic [3:0] kp;
    int         bad;
    int         ticks;
    int         last_tick;
    int         gap_bad;

    vecs[0] = '{4'hF, 18'h20001, 4'h0, 18'h20001, 4'h0, 4'h0, 1};
    vecs[1] = '{4'hE, 18'h20001, 4'h1, 18'h20001, 4'h1, 4'h0, 0};
    vecs[2] = '{4'h0, 18'h20001, 4'hF, 18'h20001, 4'hE, 4'h0, 0};
    vecs[3] = '{4'h5, 18'h20001, 4'hA, 18'h20001, 4'h0, 4'h5, 0};
    vecs[4] = '{4'hF, 18'h3FFFF, 4'h0, 18'h3FFFF, 4'h0, 4'hA, 1};
    vecs[5] = '{4'hF, 18'h00000, 4'h0, 18'h00000, 4'h0, 4'h0, 1};

    // Reset state
    rst_n = 1'b0;
    ks_if.KEY = 4'hF;
    ks_if.SW  = '0;
    clear_counts();
    run(3);
    check("rst_key_down", ks_if.KEY_DOWN, 0);
    check("rst_key_press", ks_if.KEY_PRESS, 0);
    check("rst_key_release", ks_if.KEY_RELEASE, 0);
    check("rst_sw_state", ks_if.SW_STATE, 0);
    check("rst_sw_change", ks_if.SW_CHANGE, 0);
    $display("reset: down=%h sw=%h", ks_if.KEY_DOWN, ks_if.SW_STATE);

    rst_n = 1'b1;
    clear_counts();
    run(8);
    check_pulses("post_rst", 4'h0, 4'h0, 0);

    // KEY[0] press latency and single pulse, then release
    clear_counts();
    ks_if.KEY = 4'hE;
    wait_down(4'h1, lat, kp);
    check("key0_latency_ok", (lat >= 11 && lat <= 14), 1);
    check("key0_press_at_down", kp, 4'h1);
    run(20);
    check("key0_down", ks_if.KEY_DOWN, 4'h1);
    check_pulses("key0_press", 4'h1, 4'h0, 0);
    $display("key0 press: latency=%0d down=%h", lat, ks_if.KEY_DOWN);
    clear_counts();
    ks_if.KEY = 4'hF;
    wait_down(4'h0, lat, kp);
    check("key0_rel_latency_ok", (lat >= 11 && lat <= 14), 1);
    check("key0_release_at_up", ks_if.KEY_RELEASE, 4'h1);
    run(20);
    check_pulses("key0_rel", 4'h0, 4'h1, 0);
    $display("key0 release: latency=%0d down=%h", lat, ks_if.KEY_DOWN);

    // KEY[1] bouncing every 3 cycles must never be accepted
    clear_counts();
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) ks_if.KEY[1] = ~ks_if.KEY[1];
      step();
      if (ks_if.KEY_DOWN[1] !== 1'b0) bad++;
    end
    ks_if.KEY[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ks_if.KEY_DOWN[1] !== 1'b0) bad++;
    end
    check("bounce_key1_down_cycles", bad, 0);
    check_pulses("bounce", 4'h0, 4'h0, 0);
    $display("bounce key1: bad_cycles=%0d", bad);

    // Table-driven steady-state vectors
    for (int v = 0; v < 6; v++) begin
      clear_counts();
      ks_if.KEY = vecs[v].key;
      ks_if.SW  = vecs[v].sw;
      run(20);
      check($sformatf("vec%0d_key_down", v), ks_if.KEY_DOWN, vecs[v].exp_down);
      check($sformatf("vec%0d_sw_state", v), ks_if.SW_STATE, vecs[v].exp_sw);
      check_pulses($sformatf("vec%0d", v), vecs[v].exp_press, vecs[v].exp_rel, vecs[v].exp_chg);
      $display("vec%0d: key=%h sw=%h -> down=%h sw_state=%h chg=%0d",
               v, vecs[v].key, vecs[v].sw, ks_if.KEY_DOWN, ks_if.SW_STATE, chg_cnt);
    end

    // Reset while all keys held: outputs clear at once, keys re-reported
    ks_if.KEY = 4'h0;
    ks_if.SW  = 18'h00003;
    run(20);
    check("pre_rst_down", ks_if.KEY_DOWN, 4'hF);
    rst_n = 1'b0;
    #1;
    check("async_rst_key_down", ks_if.KEY_DOWN, 0);
    check("async_rst_sw_state", ks_if.SW_STATE, 0);
    check("async_rst_pulses", {ks_if.KEY_PRESS, ks_if.KEY_RELEASE, ks_if.SW_CHANGE}, 0);
    clear_counts();
    run(4);
    check_pulses("in_rst", 4'h0, 4'h0, 0);
    rst_n = 1'b1;
    clear_counts();
    wait_down(4'hF, lat, kp);
    check("rst_hold_latency_ok", (lat >= 11 && lat <= 14), 1);
    check("rst_hold_press_all", kp, 4'hF);
    run(10);
    check("rst_hold_sw_state", ks_if.SW_STATE, 18'h00003);
    check_pulses("rst_hold", 4'hF, 4'h0, 1);
    $display("reset with keys held: latency=%0d press=%h", lat, kp);

    // Long hold: tick every TD cycles, no spurious pulses
    ks_if.KEY = 4'hF;
    ks_if.SW  = 18'h2AAAA;
    run(20);
    clear_counts();
    ks_if.KEY = 4'h0;
    run(20);
    check_pulses("hold_entry", 4'hF, 4'h0, 0);
    clear_counts();
    ticks = 0;
    last_tick = -1;
    gap_bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (dut.tick) begin
        if (last_tick >= 0 && (c - last_tick) != TD) gap_bad++;
        last_tick = c;
        ticks++;
      end
    end
    check("hold_tick_count", ticks, 1000 / TD);
    check("hold_tick_gaps", gap_bad, 0);
    check("hold_key_down", ks_if.KEY_DOWN, 4'hF);
    check("hold_sw_state", ks_if.SW_STATE, 18'h2AAAA);
    check_pulses("hold", 4'h0, 4'h0, 0);
    $display("hold 1000: ticks=%0d gap_bad=%0d", ticks, gap_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
